dis_step_counter: RTL and testbench
===================================

// Module: dis_step_counter
// PURPOSE
//  Parametrised step counter for the keypad digit-shuffle/display sequencer.
//  - Counts prescaled ticks while 'run' is held high; clears when 'run' drops.
//  - Either saturates at MAX_COUNT or wraps, selected at runtime.
//  - Adds pause, prescaling, a terminal-count flag and a one-cycle done strobe.
//  - Drives shuffle-step selection and display refresh in the lock front end.
// PARAMETERS
//  WIDTH      4   counter/output width in bits
//  MAX_COUNT  10  terminal count; must satisfy 1 <= MAX_COUNT <= 2**WIDTH-1
//  DIV        1   prescale: one count step per DIV enabled clocks; DIV >= 1
//  (illegal values -> elaboration error via generate-time check)
// PORTS
//  clk        in   1      system clock, all state on rising edge
//  rst_n      in   1      reset, asynchronous, active-low
//  run        in   1      level: 1 = count, 0 = clear to 0 and idle
//  hold       in   1      level: 1 = freeze count and prescaler (only while run=1)
//  mode_wrap  in   1      0 = saturate at MAX_COUNT, 1 = wrap MAX_COUNT -> 0
//  count_out  out  WIDTH  current count, registered
//  at_max     out  1      registered, 1 while count_out == MAX_COUNT
//  done       out  1      one-cycle strobe, high in the cycle count_out first == MAX_COUNT
//  active     out  1      registered, 1 when state != IDLE
// BEHAVIOUR
//  - Reset (rst_n=0, async):
//    - state=IDLE, count=0, prescaler=0; count_out=0, at_max=0, done=0, active=0.
//    - Release is synchronous to the next rising clk; no count step on the release edge unless run=1.
//  - States: IDLE, COUNT, SAT.
//    - IDLE  -> COUNT on an edge with run=1.
//    - COUNT -> SAT on a step reaching MAX_COUNT with mode_wrap=0.
//    - SAT   -> COUNT on a step while mode_wrap=1 (count wraps to 0).
//    - any   -> IDLE on an edge with run=0: count and prescaler cleared in that same edge.
//  - Prescaler: pre counts 0..DIV-1 on edges with run=1 & hold=0.
//    - step = run & ~hold & (pre == DIV-1); pre wraps to 0 on step.
//    - DIV=1: every enabled edge is a step.
//  - First step latency: the step fires on the DIV-th edge at which run=1 is sampled.
//    - DIV=1: count_out=1 after the first edge with run=1.
//  - On step: if count < MAX_COUNT then count+1.
//    - Else mode_wrap=1 -> count=0.
//    - Else (mode_wrap=0) hold at MAX_COUNT; SAT ignores further steps.
//  - count_out/at_max/active/done all update on the same edge as count; no combinational input->output path.
//  - done=1 for exactly the one cycle after the edge where count becomes MAX_COUNT.
//    - In wrap mode this repeats every MAX_COUNT+1 steps.
//    - Never asserted while held at MAX_COUNT.
//  - hold=1: count, pre and state frozen; done deasserts after its single cycle even if hold is set.
//  - Simultaneous run=0 with hold=1 or with a step: run=0 wins (clear).
//  - mode_wrap change takes effect at the next step; no effect on count by itself.
//  - Arithmetic: unsigned, WIDTH bits; the count never exceeds MAX_COUNT so no overflow.
//  - Prescaler width is max(1, $clog2(DIV)).
// TESTING
//  1. DIV=1, wrap=0, run=1 for 13 edges -> count_out 1..10, holds at 10; done high only in the cycle after edge 10; at_max from edge 10 on.
//  2. From saturation, run=0 for 1 edge -> count_out=0, at_max=0, active=0 after that edge; run=1 again -> restarts at 1.
//  3. DIV=3, run=1 -> count_out increments on edges 3, 6, 9, ...; hold=1 for 5 edges mid-way -> count and phase frozen, resume exactly where stopped.
//  4. wrap=1, MAX_COUNT=10 -> sequence ...9, 10, 0, 1...; done pulses at each 10; switching wrap 0->1 in SAT -> next step gives 0.
//  5. rst_n pulled low mid-count, not clock-aligned -> all outputs 0 immediately; after release with run=1, counting restarts from 1.
//  6. run deasserted on the same edge a step would hit MAX_COUNT -> count_out=0, done stays 0.

Source files
------------

// File: rtl/dis_step_counter.sv
// Step counter for the keypad digit-shuffle/display sequencer.
// It counts prescaled ticks while run is high, and saturates or wraps at MAX_COUNT.
// All outputs are registered. They update on the same edge as the count.
//
// state   | meaning
// IDLE    | run low, count and prescaler held at zero
// COUNT   | counting prescaled steps toward MAX_COUNT
// SAT     | parked at MAX_COUNT in saturate mode, further steps ignored
module dis_step_counter #(
  parameter int WIDTH     = 4,
  parameter int MAX_COUNT = 10,
  parameter int DIV       = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             run,
  input  logic             hold,
  input  logic             mode_wrap,
  output logic [WIDTH-1:0] count_out,
  output logic             at_max,
  output logic             done,
  output logic             active
);

  localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [WIDTH-1:0] MAXC     = WIDTH'(MAX_COUNT);
  localparam logic [PW-1:0]    PRE_LAST = PW'(DIV - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_COUNT = 2'd1;
  localparam logic [1:0] S_SAT   = 2'd2;

  // Reject parameter sets that would let the count overflow or the prescaler stall
  generate
    if (WIDTH < 1 || MAX_COUNT < 1 || MAX_COUNT > (2 ** WIDTH) - 1 || DIV < 1) begin : g_bad_params
      $error("dis_step_counter: illegal WIDTH/MAX_COUNT/DIV combination");
    end
  endgenerate

  logic [1:0]       r_state;
  logic [WIDTH-1:0] r_count;
  logic [PW-1:0]    r_pre;
  logic             r_at_max;
  logic             r_done;
  logic             r_active;

  logic [1:0]       w_state_nxt;
  logic [WIDTH-1:0] w_count_nxt;
  logic [WIDTH-1:0] w_count_inc;
  logic [PW-1:0]    w_pre_nxt;
  logic             w_done_nxt;
  logic             w_step;

  assign w_step      = run & ~hold & (r_pre == PRE_LAST);
  assign w_count_inc = r_count + 1'b1;

  // Next-state, count and prescaler; run=0 clears regardless of hold or step
  always_comb begin
    w_state_nxt = r_state;
    w_count_nxt = r_count;
    w_pre_nxt   = r_pre;
    w_done_nxt  = 1'b0;
    if (!run) begin
      w_state_nxt = S_IDLE;
      w_count_nxt = '0;
      w_pre_nxt   = '0;
    end else if (!hold) begin
      w_pre_nxt = w_step ? '0 : r_pre + 1'b1;
      if (r_state == S_IDLE) begin
        w_state_nxt = S_COUNT;
      end
      if (w_step) begin
        if (r_count < MAXC) begin
          w_count_nxt = w_count_inc;
          if (w_count_inc == MAXC) begin
            w_done_nxt  = 1'b1;
            w_state_nxt = mode_wrap ? S_COUNT : S_SAT;
          end
        end else if (mode_wrap) begin
          w_count_nxt = '0;
          w_state_nxt = S_COUNT;
        end else begin
          // Already at MAX_COUNT (e.g. wrap turned off at the top): park without a new done
          w_state_nxt = S_SAT;
        end
      end
    end
  end

  // Register state and all outputs together so nothing is combinational from inputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_count  <= '0;
      r_pre    <= '0;
      r_at_max <= 1'b0;
      r_done   <= 1'b0;
      r_active <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_count  <= w_count_nxt;
      r_pre    <= w_pre_nxt;
      r_at_max <= (w_count_nxt == MAXC);
      r_done   <= w_done_nxt;
      r_active <= (w_state_nxt != S_IDLE);
    end
  end

  assign count_out = r_count;
  assign at_max    = r_at_max;
  assign done      = r_done;
  assign active    = r_active;

endmodule

// File: tb/tb_dis_step_counter.sv
// Bench for dis_step_counter. Two instances (DIV=1 and DIV=3) share the clock and inputs.
// A reference model pushes expected outputs per edge into queues. The outputs are popped and compared after the edge.
module tb_dis_step_counter;

  typedef struct packed {
    logic [3:0] cnt;
    logic       at_max;
    logic       done;
    logic       active;
  } exp_t;

  logic       clk;
  logic       rst_n;
  logic       run;
  logic       hold;
  logic       mode_wrap;
  logic [3:0] cnt_a, cnt_b;
  logic       at_max_a, at_max_b, done_a, done_b, active_a, active_b;

  int checks   = 0;
  int failures = 0;

  exp_t qa[$];
  exp_t qb[$];

  int m_cnt[2];
  int m_pre[2];
  bit m_done[2];
  bit m_act[2];
  int divs[2] = '{1, 3};

  dis_step_counter #(.WIDTH(4), .MAX_COUNT(10), .DIV(1)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .run(run), .hold(hold), .mode_wrap(mode_wrap),
    .count_out(cnt_a), .at_max(at_max_a), .done(done_a), .active(active_a)
  );

  dis_step_counter #(.WIDTH(4), .MAX_COUNT(10), .DIV(3)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .run(run), .hold(hold), .mode_wrap(mode_wrap),
    .count_out(cnt_b), .at_max(at_max_b), .done(done_b), .active(active_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic void model_reset();
    for (int d = 0; d < 2; d++) begin
      m_cnt[d] = 0; m_pre[d] = 0; m_done[d] = 1'b0; m_act[d] = 1'b0;
    end
  endfunction

  function automatic exp_t model_edge(input int d, input bit r, input bit h, input bit w);
    exp_t e;
    if (!r) begin
      m_cnt[d] = 0; m_pre[d] = 0; m_done[d] = 1'b0; m_act[d] = 1'b0;
    end else begin
      m_done[d] = 1'b0;
      if (!h) begin
        m_act[d] = 1'b1;
        if (m_pre[d] == divs[d] - 1) begin
          m_pre[d] = 0;
          if (m_cnt[d] < 10) begin
            m_cnt[d]++;
            if (m_cnt[d] == 10) m_done[d] = 1'b1;
          end else if (w) begin
            m_cnt[d] = 0;
          end
        end else begin
          m_pre[d]++;
        end
      end
    end
    e.cnt    = 4'(m_cnt[d]);
    e.at_max = (m_cnt[d] == 10);
    e.done   = m_done[d];
    e.active = m_act[d];
    return e;
  endfunction

  task automatic step(input bit r, input bit h, input bit w);
    exp_t ea, eb;
    @(negedge clk);
    run = r; hold = h; mode_wrap = w;
    qa.push_back(model_edge(0, r, h, w));
    qb.push_back(model_edge(1, r, h, w));
    @(posedge clk);
    #1;
    ea = qa.pop_front();
    eb = qb.pop_front();
    chk("a_count",  int'(cnt_a),    int'(ea.cnt));
    chk("a_at_max", int'(at_max_a), int'(ea.at_max));
    chk("a_done",   int'(done_a),   int'(ea.done));
    chk("a_active", int'(active_a), int'(ea.active));
    chk("b_count",  int'(cnt_b),    int'(eb.cnt));
    chk("b_at_max", int'(at_max_b), int'(eb.at_max));
    chk("b_done",   int'(done_b),   int'(eb.done));
    chk("b_active", int'(active_b), int'(eb.active));
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_a_cnt"},  int'(cnt_a), 0);
    chk({tag, "_a_flags"}, int'({at_max_a, done_a, active_a}), 0);
    chk({tag, "_b_cnt"},  int'(cnt_b), 0);
    chk({tag, "_b_flags"}, int'({at_max_b, done_b, active_b}), 0);
  endtask

  initial begin
    rst_n = 1'b0; run = 1'b0; hold = 1'b0; mode_wrap = 1'b0;
    model_reset();
    #12;
    chk_all_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Saturating count from zero, DIV=1 reaches 10 and parks there
    for (int i = 1; i <= 13; i++) begin
      step(1, 0, 0);
      chk("t1_cnt",  int'(cnt_a),  (i < 10) ? i : 10);
      chk("t1_done", int'(done_a), (i == 10) ? 1 : 0);
    end
    chk("t1_b_cnt", int'(cnt_b), 4);

    // Drop run from saturation, then restart
    step(0, 0, 0);
    chk_all_zero("t2_clear");
    step(1, 0, 0);
    chk("t2_restart", int'(cnt_a), 1);

    // DIV=3 phase is preserved across a 5-cycle hold
    step(1, 0, 0);
    step(1, 0, 0);
    chk("t3_b_first", int'(cnt_b), 1);
    step(1, 0, 0);
    for (int i = 0; i < 5; i++) begin
      step(1, 1, 0);
      chk("t3_b_held", int'(cnt_b), 1);
    end
    step(1, 0, 0);
    chk("t3_b_resume1", int'(cnt_b), 1);
    step(1, 0, 0);
    chk("t3_b_resume2", int'(cnt_b), 2);

    // Wrap mode: 1..10,0,1..
    step(0, 0, 1);
    for (int i = 1; i <= 24; i++) begin
      step(1, 0, 1);
      chk("t4_wrap_cnt",  int'(cnt_a),  i % 11);
      chk("t4_wrap_done", int'(done_a), (i % 11 == 10) ? 1 : 0);
    end
    for (int i = 0; i < 10; i++) step(1, 0, 0);
    chk("t4_sat", int'(cnt_a), 10);
    step(1, 0, 1);
    chk("t4_sat_to_wrap", int'(cnt_a), 0);

    // run drops on the edge that would have reached MAX_COUNT
    step(0, 0, 0);
    for (int i = 0; i < 9; i++) step(1, 0, 0);
    chk("t6_pre", int'(cnt_a), 9);
    step(0, 0, 0);
    chk("t6_cnt",  int'(cnt_a),  0);
    chk("t6_done", int'(done_a), 0);

    // Asynchronous reset mid-count, off the clock edge
    for (int i = 0; i < 5; i++) step(1, 0, 0);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk_all_zero("t5_async");
    model_reset();
    @(posedge clk);
    #2;
    chk_all_zero("t5_held");
    rst_n = 1'b1;
    step(1, 0, 0);
    chk("t5_restart", int'(cnt_a), 1);
    step(1, 0, 0);
    step(1, 0, 0);
    chk("t5_b_restart", int'(cnt_b), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
